prod_accum: RTL and testbench

// - Dot-product accumulator directly downstream of the 4x4 shift-add multiplier.
// - Captures each 8-bit product when the multiplier pulses Done, and sums a vector of len products.
// - Presents the final sum on a valid/ready result port.
// - Flags arithmetic overflow, and flags products that arrive when the block is not accumulating.

---
 rtl/prod_accum.sv | 104 ++++++++++
 tb/tb_prod_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Dot-product accumulator that sits behind the shift-add multiplier: it sums len products,
// one per Done pulse, and presents the sum on a valid/ready result port with overflow and drop flags.
module prod_accum #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_done,
    input  logic [7:0]       prod,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res,
    output logic             res_ovf,
    output logic             err_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Result handshake: res/res_ovf are stable while res_valid=1; a transfer happens on
    // any posedge where res_valid and res_ready are both 1, and res_valid drops the next cycle.
    state_t           state, state_next;
    logic [ACC_W-1:0] sum, sum_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    logic             ovf_next;
    logic             drop_next;
    logic [ACC_W:0]   sum_ext;

    // One extra bit so the carry out of the running sum is visible as overflow.
    assign sum_ext = {1'b0, sum} + {{(ACC_W - 7){1'b0}}, prod};

    always_comb begin
        state_next     = state;
        sum_next       = sum;
        remaining_next = remaining;
        ovf_next       = res_ovf;
        drop_next      = err_drop;
        case (state)
            IDLE: begin
                if (start) begin
                    // An accepted start clears the drop flag even if a stray product arrives with it.
                    sum_next       = '0;
                    ovf_next       = 1'b0;
                    drop_next      = 1'b0;
                    remaining_next = len;
                    state_next     = (len == '0) ? HOLD : ACCUM;
                end else if (prod_done) begin
                    drop_next = 1'b1;
                end
            end
            ACCUM: begin
                if (prod_done) begin
                    sum_next       = sum_ext[ACC_W-1:0];
                    remaining_next = remaining - 1'b1;
                    if (sum_ext[ACC_W]) begin
                        ovf_next = 1'b1;
                    end
                    if (remaining == CNT_W'(1)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (prod_done) begin
                    drop_next = 1'b1;
                end
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum       <= '0;
            remaining <= '0;
            res_ovf   <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            state     <= state_next;
            sum       <= sum_next;
            remaining <= remaining_next;
            res_ovf   <= ovf_next;
            err_drop  <= drop_next;
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);
    assign res       = sum;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a 12-bit and an 8-bit accumulator share the same stimulus,
// each checked against hand-computed values.
module tb_prod_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        prod_done;
    logic [7:0]  prod;
    logic        res_ready;

    logic        busy, res_valid, res_ovf, err_drop;
    logic [11:0] res;
    logic        busy8, res_valid8, res_ovf8, err_drop8;
    logic [7:0]  res8;

    int n_checks = 0;
    int n_fail   = 0;

    prod_accum #(.ACC_W(12), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_done(prod_done), .prod(prod), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res(res), .res_ovf(res_ovf), .err_drop(err_drop)
    );

    prod_accum #(.ACC_W(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_done(prod_done), .prod(prod), .busy(busy8), .res_valid(res_valid8),
        .res_ready(res_ready), .res(res8), .res_ovf(res_ovf8), .err_drop(err_drop8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one posedge; outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_prod(input logic [7:0] p);
        prod_done = 1'b1;
        prod      = p;
        step();
        prod_done = 1'b0;
        prod      = 8'h00;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 4'd0;
        prod_done = 1'b0; prod = 8'h00; res_ready = 1'b0;
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_res", res, 12'h000);
        rst_n = 1'b1;
        step();

        // 1. reset in the middle of a vector
        do_start(4'd3);
        check("t1_busy", busy, 1'b1);
        pulse_prod(8'h20);
        rst_n = 1'b0;
        step(); step();
        check("t1_busy", busy, 1'b0);
        check("t1_valid", res_valid, 1'b0);
        check("t1_res", res, 12'h000);
        check("t1_ovf", res_ovf, 1'b0);
        check("t1_drop", err_drop, 1'b0);
        rst_n = 1'b1;
        step();

        // 2. three products on separate pulses
        do_start(4'd3);
        check("t2_busy", busy, 1'b1);
        check("t2_valid0", res_valid, 1'b0);
        pulse_prod(8'h0F);
        step();
        pulse_prod(8'hE1);
        check("t2_valid1", res_valid, 1'b0);
        pulse_prod(8'h06);
        check("t2_valid", res_valid, 1'b1);
        check("t2_res", res, 12'h0F6);
        check("t2_ovf", res_ovf, 1'b0);
        check("t2_res8", res8, 8'hF6);
        check("t2_ovf8", res_ovf8, 1'b0);
        accept();
        check("t2_valid_done", res_valid, 1'b0);
        check("t2_busy_done", busy, 1'b0);

        // 3. overflow on the 8-bit accumulator, cleared by the next start
        do_start(4'd2);
        pulse_prod(8'hE1);
        pulse_prod(8'hE1);
        check("t3_valid", res_valid, 1'b1);
        check("t3_res12", res, 12'h1C2);
        check("t3_ovf12", res_ovf, 1'b0);
        check("t3_res8", res8, 8'hC2);
        check("t3_ovf8", res_ovf8, 1'b1);
        accept();
        check("t3_ovf8_sticky", res_ovf8, 1'b1);
        do_start(4'd1);
        check("t3_ovf8_clr", res_ovf8, 1'b0);
        pulse_prod(8'h01);
        check("t3_res8_b", res8, 8'h01);
        check("t3_ovf8_b", res_ovf8, 1'b0);
        check("t3_res12_b", res, 12'h001);
        accept();

        // 4. backpressure in HOLD with a stray product
        do_start(4'd1);
        pulse_prod(8'h33);
        check("t4_drop0", err_drop, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                pulse_prod(8'h10);
            end else begin
                step();
            end
            check("t4_hold_valid", res_valid, 1'b1);
            check("t4_hold_res", res, 12'h033);
        end
        check("t4_drop", err_drop, 1'b1);
        accept();
        check("t4_valid_done", res_valid, 1'b0);
        check("t4_busy_done", busy, 1'b0);
        check("t4_drop_sticky", err_drop, 1'b1);

        // 5. zero-length vector, then start pulses ignored during ACCUM
        do_start(4'd0);
        check("t5_valid", res_valid, 1'b1);
        check("t5_res", res, 12'h000);
        check("t5_drop_clr", err_drop, 1'b0);
        accept();
        do_start(4'd2);
        start = 1'b1; len = 4'd5;
        pulse_prod(8'h05);
        check("t5_busy_a", busy, 1'b1);
        check("t5_valid_a", res_valid, 1'b0);
        len = 4'd0;
        step();
        start = 1'b0;
        check("t5_busy_b", busy, 1'b1);
        check("t5_valid_b", res_valid, 1'b0);
        pulse_prod(8'h07);
        check("t5_valid_c", res_valid, 1'b1);
        check("t5_res_c", res, 12'h00C);
        check("t5_drop_c", err_drop, 1'b0);
        accept();

        // 6. back-to-back products, then start coincident with the transfer
        do_start(4'd3);
        prod_done = 1'b1; prod = 8'h01;
        step(); step();
        check("t6_valid_mid", res_valid, 1'b0);
        step();
        prod_done = 1'b0; prod = 8'h00;
        check("t6_valid", res_valid, 1'b1);
        check("t6_res", res, 12'h003);
        res_ready = 1'b1; start = 1'b1; len = 4'd2;
        step();
        res_ready = 1'b0; start = 1'b0; len = 4'd0;
        check("t6_valid_done", res_valid, 1'b0);
        check("t6_busy_done", busy, 1'b0);
        step();
        check("t6_busy_idle", busy, 1'b0);
        check("t6_res_kept", res, 12'h003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
